// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, the HALT encoding and the fetch FSM states.
// Decode and the branch unit import this package for PC_W and HALT_INSTR.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_incrementer.sv
// Unsigned +1 on a program counter. The carry out is dropped, so the result wraps modulo 2^PC_W.
module pc_incrementer
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pcIn,
    output logic [PC_W-1:0] pcOut
);

    assign pcOut = pcIn + PC_W'(1);

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, reads instruction memory and fills the IF/ID register
// under a valid/ready handshake toward decode, with redirect flush and HALT stop.
//
//   state  | meaning
//   RUN    | fetching one word per advancing cycle
//   HALTED | HALT word latched; PC frozen until a redirect arrives
module fetch_stage
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus1,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t    state;
    logic [PC_W-1:0] pcReg;
    logic [PC_W-1:0] pcPlus1;
    logic            advance;
    logic            accepted;

    // One incrementer feeds both the next-PC path and id_pc_plus1, which is only
    // ever loaded alongside id_pc <= pcReg.
    pc_incrementer uPcInc (
        .pcIn  (pcReg),
        .pcOut (pcPlus1)
    );

    assign imem_addr = pcReg;
    assign advance   = !id_valid || id_ready;
    assign accepted  = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pcReg       <= '0;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus1 <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // A handshake completing alongside a redirect still counts as delivered.
            if (accepted && (fetch_count != CNT_MAX)) begin
                fetch_count <= fetch_count + CNT_ONE;
            end

            if (redirect_valid) begin
                pcReg    <= redirect_pc;
                id_valid <= 1'b0;
                state    <= RUN;
                halted   <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (advance) begin
                            id_instr    <= imem_data;
                            id_pc       <= pcReg;
                            id_pc_plus1 <= pcPlus1;
                            id_valid    <= 1'b1;
                            if (imem_data == HALT_INSTR) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end else begin
                                pcReg <= pcPlus1;
                            end
                        end
                    end
                    HALTED: begin
                        if (id_ready) begin
                            id_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each scenario task drives its stimulus and checks inline
// against hand-computed values; a behavioural memory array serves the instruction reads.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [PC_W-1:0]    imemAddr;
    logic [INSTR_W-1:0] imemData;
    logic               redirectValid;
    logic [PC_W-1:0]    redirectPc;
    logic               idValid;
    logic               idReady;
    logic [INSTR_W-1:0] idInstr;
    logic [PC_W-1:0]    idPc;
    logic [PC_W-1:0]    idPcPlus1;
    logic               halted;
    logic [CNT_W-1:0]   fetchCount;

    logic [INSTR_W-1:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imemAddr),
        .imem_data      (imemData),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .id_valid       (idValid),
        .id_ready       (idReady),
        .id_instr       (idInstr),
        .id_pc          (idPc),
        .id_pc_plus1    (idPcPlus1),
        .halted         (halted),
        .fetch_count    (fetchCount)
    );

    function automatic logic [INSTR_W-1:0] word(input int a);
        return 32'h1000_0000 + INSTR_W'(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        redirectValid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idReady = 1'b1;
        redirectPc = 8'h55;
        redirectValid = 1'b1;
        rst = 1'b1;
        step();
        step();
        total++;
        if ({idValid, halted, imemAddr, idPc, idPcPlus1, idInstr, fetchCount} !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b halted=%0b addr=%h pc=%h pc1=%h instr=%h cnt=%0d, want all zero",
                     idValid, halted, imemAddr, idPc, idPcPlus1, idInstr, fetchCount);
        end
        rst = 1'b0;
        redirectValid = 1'b0;
    endtask

    task automatic test_free_run();
        idReady = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (!idValid || idPc !== PC_W'(i) || idInstr !== word(i) || fetchCount !== CNT_W'(i)) begin
                bad++;
                $display("FAIL free_run[%0d]: valid=%0b pc=%h instr=%h cnt=%0d, want 1 %h %h %0d",
                         i, idValid, idPc, idInstr, fetchCount, i, word(i), i);
            end
        end
        step();
        total++;
        if (fetchCount !== 16'd4) begin
            bad++;
            $display("FAIL free_run_count: got %0d want 4", fetchCount);
        end
    endtask

    task automatic test_stall();
        idReady = 1'b0;
        doReset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (!idValid || idPc !== 8'h00 || idInstr !== word(0) || imemAddr !== 8'h01 || fetchCount !== 16'd0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: valid=%0b pc=%h instr=%h addr=%h cnt=%0d, want 1 00 %h 01 0",
                         i, idValid, idPc, idInstr, imemAddr, fetchCount, word(0));
            end
        end
        idReady = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            total++;
            if (!idValid || idPc !== PC_W'(i) || idInstr !== word(i) || fetchCount !== CNT_W'(i)) begin
                bad++;
                $display("FAIL stall_release[%0d]: valid=%0b pc=%h instr=%h cnt=%0d, want 1 %h %h %0d",
                         i, idValid, idPc, idInstr, fetchCount, i, word(i), i);
            end
        end
    endtask

    task automatic test_redirect_stall();
        idReady = 1'b1;
        doReset();
        repeat (6) step();
        idReady = 1'b0;
        step();
        total++;
        if (!idValid || idPc !== 8'h05 || fetchCount !== 16'd5) begin
            bad++;
            $display("FAIL redir_pre: valid=%0b pc=%h cnt=%0d, want 1 05 5", idValid, idPc, fetchCount);
        end
        redirectValid = 1'b1;
        redirectPc = 8'h40;
        step();
        redirectValid = 1'b0;
        total++;
        if (idValid !== 1'b0 || imemAddr !== 8'h40 || fetchCount !== 16'd5) begin
            bad++;
            $display("FAIL redir_bubble: valid=%0b addr=%h cnt=%0d, want 0 40 5", idValid, imemAddr, fetchCount);
        end
        idReady = 1'b1;
        step();
        total++;
        if (!idValid || idPc !== 8'h40 || idInstr !== word(8'h40) || idPcPlus1 !== 8'h41 || fetchCount !== 16'd5) begin
            bad++;
            $display("FAIL redir_target: valid=%0b pc=%h instr=%h pc1=%h cnt=%0d, want 1 40 %h 41 5",
                     idValid, idPc, idInstr, idPcPlus1, fetchCount, word(8'h40));
        end
        // Redirect while the current word is being accepted: the accept still counts.
        redirectValid = 1'b1;
        redirectPc = 8'h10;
        step();
        redirectValid = 1'b0;
        total++;
        if (idValid !== 1'b0 || imemAddr !== 8'h10 || fetchCount !== 16'd6) begin
            bad++;
            $display("FAIL redir_accept: valid=%0b addr=%h cnt=%0d, want 0 10 6", idValid, imemAddr, fetchCount);
        end
    endtask

    task automatic test_wrap();
        idReady = 1'b1;
        doReset();
        redirectValid = 1'b1;
        redirectPc = 8'hFE;
        step();
        redirectValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [PC_W-1:0] expPc;
            logic [PC_W-1:0] expPc1;
            expPc  = PC_W'(8'hFE + i);
            expPc1 = PC_W'(8'hFF + i);
            step();
            total++;
            if (!idValid || idPc !== expPc || idPcPlus1 !== expPc1 || idInstr !== word(int'(expPc))) begin
                bad++;
                $display("FAIL wrap[%0d]: valid=%0b pc=%h pc1=%h instr=%h, want 1 %h %h %h",
                         i, idValid, idPc, idPcPlus1, idInstr, expPc, expPc1, word(int'(expPc)));
            end
        end
    endtask

    task automatic test_halt();
        mem[3] = HALT_INSTR;
        idReady = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (!idValid || idPc !== PC_W'(i) || halted !== (i == 3)) begin
                bad++;
                $display("FAIL halt_seq[%0d]: valid=%0b pc=%h halted=%0b, want 1 %h %0b",
                         i, idValid, idPc, halted, i, (i == 3));
            end
        end
        total++;
        if (idInstr !== HALT_INSTR || imemAddr !== 8'h03) begin
            bad++;
            $display("FAIL halt_word: instr=%h addr=%h, want ffffffff 03", idInstr, imemAddr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (idValid !== 1'b0 || halted !== 1'b1 || imemAddr !== 8'h03 || fetchCount !== 16'd4) begin
                bad++;
                $display("FAIL halt_idle[%0d]: valid=%0b halted=%0b addr=%h cnt=%0d, want 0 1 03 4",
                         i, idValid, halted, imemAddr, fetchCount);
            end
        end
        redirectValid = 1'b1;
        redirectPc = 8'h00;
        step();
        redirectValid = 1'b0;
        total++;
        if (halted !== 1'b0 || idValid !== 1'b0 || imemAddr !== 8'h00) begin
            bad++;
            $display("FAIL halt_redir: halted=%0b valid=%0b addr=%h, want 0 0 00", halted, idValid, imemAddr);
        end
        step();
        total++;
        if (!idValid || idPc !== 8'h00 || idInstr !== word(0) || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_refetch: valid=%0b pc=%h instr=%h halted=%0b, want 1 00 %h 0",
                     idValid, idPc, idInstr, halted, word(0));
        end
        mem[3] = word(3);
    endtask

    task automatic test_mid_reset();
        idReady = 1'b1;
        doReset();
        repeat (8) step();
        total++;
        if (!idValid || idPc !== 8'h07 || fetchCount !== 16'd7) begin
            bad++;
            $display("FAIL midrst_pre: valid=%0b pc=%h cnt=%0d, want 1 07 7", idValid, idPc, fetchCount);
        end
        rst = 1'b1;
        redirectValid = 1'b1;
        redirectPc = 8'h33;
        step();
        rst = 1'b0;
        redirectValid = 1'b0;
        total++;
        if ({idValid, halted, imemAddr, idPc, idPcPlus1, idInstr, fetchCount} !== '0) begin
            bad++;
            $display("FAIL midrst_state: valid=%0b halted=%0b addr=%h pc=%h pc1=%h instr=%h cnt=%0d, want all zero",
                     idValid, halted, imemAddr, idPc, idPcPlus1, idInstr, fetchCount);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        rst = 1'b1;
        idReady = 1'b0;
        redirectValid = 1'b0;
        redirectPc = '0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Sequential front end of the pipeline: owns the program counter, addresses the 256-word instruction memory, and registers each fetched word into the IF/ID pipeline register with a valid/ready handshake toward decode. Accepts branch/jump redirects from downstream, flushes the in-flight fetch, and stops fetching on a HALT word until redirected. Sits between the instruction memory (combinational read) and the decode stage.

## Interface
- PC_W, 8, program counter / instruction-memory address width
- INSTR_W, 32, instruction width
- CNT_W, 16, width of the delivered-instruction counter
- clk  input  1  rising-edge clock; only clock
- rst  input  1  synchronous, active-high reset
- imem_addr  output  PC_W  address to instruction memory; equals current PC
- imem_data  input  INSTR_W  word at imem_addr, valid in the same cycle
- redirect_valid  input  1  load redirect_pc and flush this cycle
- redirect_pc  input  PC_W  redirect target
- id_valid  output  1  IF/ID register holds an instruction
- id_ready  input  1  decode accepts the instruction this cycle
- id_instr  output  INSTR_W  registered instruction
- id_pc  output  PC_W  address of id_instr
- id_pc_plus1  output  PC_W  id_pc + 1, mod 2^PC_W
- halted  output  1  high in HALTED state
- fetch_count  output  CNT_W  count of accepted handshakes (id_valid & id_ready), saturating

## Operation
- States: RUN, HALTED. Reset → RUN.
- Reset values: pc=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus1=0, halted=0, fetch_count=0.
- imem_addr = pc, combinational.
- advance = !id_valid | id_ready.
- Priority per cycle: rst > redirect_valid > advance > hold.
- redirect_valid (either state): pc←redirect_pc, id_valid←0, state←RUN. Current imem_data is discarded.
- RUN and advance: id_instr←imem_data, id_pc←pc, id_pc_plus1←pc+1, id_valid←1.
  - If imem_data == HALT_INSTR (32'hFFFF_FFFF): pc holds, state←HALTED. The HALT word itself is delivered to decode.
  - Otherwise pc←pc+1, wrapping 8'hFF→8'h00.
- RUN and !advance (stall): pc, id_* and state hold; id_instr remains stable while id_valid & !id_ready.
- HALTED, no redirect: no fetch; pc holds; if id_ready then id_valid←0; otherwise id_* hold.
- fetch_count increments on every cycle with id_valid & id_ready, including a cycle that also carries redirect_valid. It stops at all-ones; it does not wrap.
- All arithmetic is unsigned and modulo 2^PC_W. No sign extension.

## Timing
- Fetch latency: the word at pc appears on id_* one clock after the advancing edge.
- Throughput: one instruction per cycle while id_ready stays high.
- Redirect penalty: id_valid is 0 for exactly one cycle. The target instruction is valid at the second edge after redirect_valid is sampled.
- Redirect in the same cycle as a stall: the held instruction is dropped, not delivered.
- rst asserted mid-stream: all state returns to reset values at the next edge regardless of other inputs.
- halted rises on the same edge that latches the HALT word.

## Structure
- Shared package fetch_pkg holds:
  - PC_W, INSTR_W, CNT_W
  - HALT_INSTR
  - the fetch_state_t enum {RUN, HALTED}
- Decode and the branch unit import the same package for PC_W and HALT_INSTR.
- One sub-module, pc_incrementer (PC_W in, PC_W out, +1 modulo 2^PC_W). It is instantiated once and shared by the pc next-value path and id_pc_plus1.
- Everything else is in a single always block plus the combinational imem_addr assign.

## Test plan
- Reset, then free run with id_ready=1 and memory words 0..3 = A,B,C,D → id_pc = 0,1,2,3 on consecutive cycles; fetch_count=4 after 4 accepts.
- Hold id_ready=0 for 3 cycles after the first valid → id_instr/id_pc frozen at word 0, pc=1, fetch_count unchanged; release → words 1, 2 follow back-to-back.
- Redirect to 8'h40 while word 5 is valid and stalled → word 5 never accepted, id_valid low for one cycle, then id_pc=8'h40.
- Preload memory so word 8'hFF ≠ HALT; start at 8'hFE → id_pc sequence FE, FF, 00, and id_pc_plus1 for FF equals 00.
- HALT_INSTR at word 3 → words 0–3 delivered, halted=1 and pc=3 held, id_valid drops after accept; redirect to 0 → halted=0 and word 0 refetched.
- Pulse rst mid-stream with id_valid=1 and fetch_count=7 → next cycle all outputs at reset values and imem_addr=0.
